// File: rtl/clock_control.sv
// Clock control front-end: 1 Hz prescaler, button synchronise/debounce,
// Set auto-repeat and the RUN -> SET_HOUR -> SET_MIN mode FSM. Every output
// is a registered single-cycle strobe or level consumed by clock_counters.
module clock_control #(
   parameter int unsigned TICK_DIV        = 50_000_000,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned REPEAT_DELAY    = 25_000_000,
   parameter int unsigned REPEAT_PERIOD   = 10_000_000,
   parameter int unsigned BLINK_DIV       = 25_000_000
) (
   input  logic       i_Clock,
   input  logic       i_Reset_n,
   input  logic       i_Button_Mode,
   input  logic       i_Button_Set,
   output logic       o_Reset_Sec,
   output logic       o_Enable_Increment,
   output logic       o_Enable_Count_Sec,
   output logic       o_Enable_Count_Min,
   output logic       o_Enable_Count_Hour,
   output logic [1:0] o_Mode,
   output logic       o_Blink
);

   localparam int unsigned TW = $clog2(TICK_DIV + 1);
   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RW = $clog2(RMAX + 1);
   localparam int unsigned BW = $clog2(BLINK_DIV + 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_SET_HOUR = 2'b01,
      ST_SET_MIN  = 2'b10
   } state_e;

   // Button index 0 = Mode, 1 = Set
   logic [1:0]    raw;
   logic [1:0]    sync1_q, sync2_q, deb_q, deb_prev_q;
   logic [DW-1:0] deb_cnt_q [2];
   logic          mode_press, set_press;

   state_e        state_q, state_d;
   logic [TW-1:0] presc_q, presc_d;
   logic          rep_act_q, rep_act_d;
   logic          rep_first_q, rep_first_d;
   logic [RW-1:0] rep_cnt_q, rep_cnt_d;
   logic          blink_q, blink_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          rst_sec_q, rst_sec_d;
   logic          inc_q, inc_d;
   logic          sec_q, sec_d;
   logic          min_q, min_d;
   logic          hour_q, hour_d;
   logic          tick, rep_fire;

   assign raw        = {i_Button_Set, i_Button_Mode};
   assign mode_press = deb_q[0] & ~deb_prev_q[0];
   assign set_press  = deb_q[1] & ~deb_prev_q[1];

   // Synchronise both buttons and accept a new level after DEBOUNCE_CYCLES equal samples
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
         for (int unsigned i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
      end else begin
         sync1_q    <= raw;
         sync2_q    <= sync1_q;
         deb_prev_q <= deb_q;
         for (int unsigned i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
               deb_cnt_q[i] <= '0;
            end else if (deb_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
               deb_q[i]     <= sync2_q[i];
               deb_cnt_q[i] <= '0;
            end else begin
               deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Next-state and strobe decode: mode change, prescaler tick, increment/repeat, blink
   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      rep_act_d   = rep_act_q;
      rep_first_d = rep_first_q;
      rep_cnt_d   = rep_cnt_q;
      blink_d     = blink_q;
      blink_cnt_d = blink_cnt_q;
      rst_sec_d   = 1'b0;
      inc_d       = 1'b0;
      sec_d       = 1'b0;
      min_d       = 1'b0;
      hour_d      = 1'b0;

      tick     = (state_q == ST_RUN) && (presc_q == TW'(TICK_DIV - 1));
      rep_fire = rep_act_q && deb_q[1] &&
                 (rep_cnt_q == (rep_first_q ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1)));

      if (rep_act_q) begin
         if (rep_fire) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
         end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
         end
      end
      if (!deb_q[1]) rep_act_d = 1'b0;

      if (state_q == ST_RUN) presc_d = tick ? '0 : presc_q + 1'b1;
      else                   presc_d = '0;

      if (state_q == ST_RUN) begin
         blink_d     = 1'b0;
         blink_cnt_d = '0;
      end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
         blink_d     = ~blink_q;
         blink_cnt_d = '0;
      end else begin
         blink_cnt_d = blink_cnt_q + 1'b1;
      end

      if (tick) begin
         sec_d  = 1'b1;
         min_d  = 1'b1;
         hour_d = 1'b1;
      end

      // A Mode press takes priority over a coincident Set press or repeat
      if (mode_press) begin
         rep_act_d = 1'b0;
         presc_d   = '0;
         case (state_q)
            ST_RUN:      state_d = ST_SET_HOUR;
            ST_SET_HOUR: state_d = ST_SET_MIN;
            default: begin
               state_d   = ST_RUN;
               rst_sec_d = 1'b1;
            end
         endcase
         blink_d     = (state_d != ST_RUN);
         blink_cnt_d = '0;
      end else if ((state_q != ST_RUN) && (set_press || rep_fire)) begin
         inc_d  = 1'b1;
         hour_d = (state_q == ST_SET_HOUR);
         min_d  = (state_q == ST_SET_MIN);
         if (set_press) begin
            rep_act_d   = 1'b1;
            rep_first_d = 1'b1;
            rep_cnt_d   = '0;
         end
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q     <= ST_RUN;
         presc_q     <= '0;
         rep_act_q   <= 1'b0;
         rep_first_q <= 1'b0;
         rep_cnt_q   <= '0;
         blink_q     <= 1'b0;
         blink_cnt_q <= '0;
         rst_sec_q   <= 1'b0;
         inc_q       <= 1'b0;
         sec_q       <= 1'b0;
         min_q       <= 1'b0;
         hour_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         rep_act_q   <= rep_act_d;
         rep_first_q <= rep_first_d;
         rep_cnt_q   <= rep_cnt_d;
         blink_q     <= blink_d;
         blink_cnt_q <= blink_cnt_d;
         rst_sec_q   <= rst_sec_d;
         inc_q       <= inc_d;
         sec_q       <= sec_d;
         min_q       <= min_d;
         hour_q      <= hour_d;
      end
   end

   assign o_Reset_Sec         = rst_sec_q;
   assign o_Enable_Increment  = inc_q;
   assign o_Enable_Count_Sec  = sec_q;
   assign o_Enable_Count_Min  = min_q;
   assign o_Enable_Count_Hour = hour_q;
   assign o_Mode              = state_q;
   assign o_Blink             = blink_q;

endmodule

// File: tb/tb_clock_control.sv
// Bench for clock_control: directed scenarios plus random button activity,
// every cycle compared against a time-stamp based reference model.
module tb_clock_control;

   localparam int TD = 4;
   localparam int DC = 3;
   localparam int RD = 20;
   localparam int RP = 5;
   localparam int BD = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       b_mode = 1'b0;
   logic       b_set = 1'b0;
   logic       o_rst, o_inc, o_sec, o_min, o_hour, o_blink;
   logic [1:0] o_mode;

   int n_checks = 0;
   int n_errors = 0;
   int cyc_no = 0;

   clock_control #(
      .TICK_DIV(TD),
      .DEBOUNCE_CYCLES(DC),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP),
      .BLINK_DIV(BD)
   ) dut (
      .i_Clock(clk),
      .i_Reset_n(rst_n),
      .i_Button_Mode(b_mode),
      .i_Button_Set(b_set),
      .o_Reset_Sec(o_rst),
      .o_Enable_Increment(o_inc),
      .o_Enable_Count_Sec(o_sec),
      .o_Enable_Count_Min(o_min),
      .o_Enable_Count_Hour(o_hour),
      .o_Mode(o_mode),
      .o_Blink(o_blink)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (event time stamps) ----------------
   int   n;            // edges since reset release
   int   m_mode;       // 0 RUN, 1 SET_HOUR, 2 SET_MIN
   int   run_start, entry, press_p;
   bit   rep_act;
   bit   deb_cur [2];
   bit   deb_prev [2];
   bit   hm [$];
   bit   hs [$];
   logic [7:0] e_out;

   function automatic bit synced(int b, int e);
      if (e < 3) return 1'b0;
      return (b == 0) ? hm[e-3] : hs[e-3];
   endfunction

   task automatic model_reset();
      n = 0; m_mode = 0; run_start = 0; entry = 0; press_p = 0; rep_act = 0;
      deb_cur[0] = 0; deb_cur[1] = 0; deb_prev[0] = 0; deb_prev[1] = 0;
      hm.delete(); hs.delete();
      e_out = '0;
   endtask

   task automatic model_step();
      bit mp, sp, lvl, tk, fire, w, stable;
      bit r_s, i_s, s_s, mi_s, h_s, bl;
      n++;
      hm.push_back(b_mode);
      hs.push_back(b_set);
      mp  = deb_cur[0] & ~deb_prev[0];
      sp  = deb_cur[1] & ~deb_prev[1];
      lvl = deb_cur[1];
      for (int b = 0; b < 2; b++) begin
         w = synced(b, n);
         stable = 1;
         for (int k = 0; k < DC; k++) if (synced(b, n - k) != w) stable = 0;
         deb_prev[b] = deb_cur[b];
         if (stable) deb_cur[b] = w;
      end
      r_s = 0; i_s = 0; s_s = 0; mi_s = 0; h_s = 0;
      tk = (m_mode == 0) && (n > run_start) && (((n - run_start) % TD) == 0);
      if (tk) begin s_s = 1; mi_s = 1; h_s = 1; end
      if (!lvl) rep_act = 0;
      fire = rep_act && lvl && ((n - press_p) >= RD) && (((n - press_p - RD) % RP) == 0);
      if (mp) begin
         rep_act = 0;
         if (m_mode == 2) begin
            m_mode = 0; r_s = 1; run_start = n;
         end else begin
            m_mode++; entry = n;
         end
      end else if (m_mode != 0 && (sp || fire)) begin
         i_s = 1; h_s = (m_mode == 1); mi_s = (m_mode == 2);
         if (sp) begin rep_act = 1; press_p = n; end
      end
      bl = (m_mode != 0) && ((((n - entry) / BD) % 2) == 0);
      e_out = {r_s, i_s, s_s, mi_s, h_s, 2'(m_mode), bl};
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_no);
      end
   endtask

   function automatic logic [7:0] outs();
      return {o_rst, o_inc, o_sec, o_min, o_hour, o_mode, o_blink};
   endfunction

   task automatic cyc();
      @(negedge clk);
      cyc_no++;
      check_val("outs", 32'(outs()), 32'(e_out));
   endtask

   task automatic pulse(input logic m, input logic s, input int hold, input int total,
                        output int c_inc, output int c_sec, output int c_min,
                        output int c_hour, output int c_rs);
      c_inc = 0; c_sec = 0; c_min = 0; c_hour = 0; c_rs = 0;
      b_mode = m; b_set = s;
      for (int i = 0; i < total; i++) begin
         if (i == hold) begin b_mode = 0; b_set = 0; end
         cyc();
         c_inc += int'(o_inc); c_sec += int'(o_sec); c_min += int'(o_min);
         c_hour += int'(o_hour); c_rs += int'(o_rst);
      end
      b_mode = 0; b_set = 0;
   endtask

   int ci, cs, cm, ch, cr;
   int rst_at, sec_at;

   initial begin
      // 1: reset and free-running ticks
      repeat (3) cyc();
      check_val("reset_outs", 32'(outs()), 32'h0);
      rst_n = 1;
      pulse(0, 0, 0, 40, ci, cs, cm, ch, cr);
      check_val("run_sec_ticks", 32'(cs), 32'd10);
      check_val("run_hour_ticks", 32'(ch), 32'd10);
      check_val("run_inc", 32'(ci), 32'd0);

      // 2: Mode press latency, no ticks in SET_HOUR, glitch rejected
      b_mode = 1;
      repeat (5) cyc();
      check_val("mode_lat_5", 32'(o_mode), 32'd0);
      cyc();
      check_val("mode_lat_6", 32'(o_mode), 32'd1);
      repeat (4) cyc();
      b_mode = 0;
      pulse(0, 0, 0, 20, ci, cs, cm, ch, cr);
      check_val("no_tick_set", 32'(cs), 32'd0);
      pulse(1, 0, 2, 15, ci, cs, cm, ch, cr);
      check_val("glitch_mode", 32'(o_mode), 32'd1);

      // 3: single Set press in SET_HOUR then SET_MIN
      pulse(0, 1, 8, 20, ci, cs, cm, ch, cr);
      check_val("sh_inc", 32'(ci), 32'd1);
      check_val("sh_hour", 32'(ch), 32'd1);
      check_val("sh_min", 32'(cm), 32'd0);
      pulse(1, 0, 8, 15, ci, cs, cm, ch, cr);
      check_val("to_set_min", 32'(o_mode), 32'd2);
      pulse(0, 1, 8, 20, ci, cs, cm, ch, cr);
      check_val("sm_inc", 32'(ci), 32'd1);
      check_val("sm_min", 32'(cm), 32'd1);
      check_val("sm_hour", 32'(ch), 32'd0);

      // 4: hold Set 50 cycles: press, +20, +25, +30, +35, +40, +45
      pulse(0, 1, 50, 70, ci, cs, cm, ch, cr);
      check_val("repeat_inc", 32'(ci), 32'd7);
      check_val("repeat_min", 32'(cm), 32'd7);

      // 5: SET_MIN -> RUN, one seconds clear, first tick 4 cycles later
      rst_at = -1; sec_at = -1; cr = 0;
      b_mode = 1;
      for (int i = 0; i < 20; i++) begin
         if (i == 8) b_mode = 0;
         cyc();
         cr += int'(o_rst);
         if (o_rst && rst_at < 0) rst_at = cyc_no;
         if (o_sec && sec_at < 0 && rst_at >= 0) sec_at = cyc_no;
      end
      check_val("back_to_run", 32'(o_mode), 32'd0);
      check_val("reset_sec_cnt", 32'(cr), 32'd1);
      check_val("first_tick", 32'(sec_at - rst_at), 32'd4);

      // 6: simultaneous Mode+Set in SET_HOUR, then reset mid-repeat
      pulse(1, 0, 8, 15, ci, cs, cm, ch, cr);
      check_val("enter_sh", 32'(o_mode), 32'd1);
      pulse(1, 1, 8, 15, ci, cs, cm, ch, cr);
      check_val("both_mode", 32'(o_mode), 32'd2);
      check_val("both_no_inc", 32'(ci), 32'd0);
      b_set = 1;
      repeat (30) cyc();
      #2 rst_n = 0;
      #1 check_val("async_rst", 32'(outs()), 32'h0);
      b_set = 0;
      repeat (2) cyc();
      rst_n = 1;
      pulse(0, 0, 0, 10, ci, cs, cm, ch, cr);
      check_val("resume_run", 32'(o_mode), 32'd0);

      // Random button activity against the model
      for (int k = 0; k < 150; k++) begin
         int r, which, hold, gap;
         r = int'($urandom_range(0, 99));
         if (r < 3) begin
            rst_n = 0; b_mode = 0; b_set = 0;
            repeat (int'($urandom_range(1, 3))) cyc();
            rst_n = 1;
         end else begin
            which = int'($urandom_range(0, 9));
            hold  = int'($urandom_range(1, 45));
            gap   = int'($urandom_range(1, 30));
            b_mode = (which < 3) || (which == 9);
            b_set  = (which >= 3);
            repeat (hold) cyc();
            b_mode = 0; b_set = 0;
            repeat (gap) cyc();
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
